// File: rtl/uart_pkg.sv
// Shared UART receive definitions: frame field positions, widths and timing constants.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int SAMPLE_W    = 11;

  localparam int START_BIT = 1;
  localparam int DATA_LSB  = 2;
  localparam int DATA_MSB  = 9;
  localparam int PAR_BIT   = 10;
  localparam int STOP_BIT  = 11;

  // One frame lasts 11 bits at 5 clocks per bit.
  localparam int FRAME_CLKS      = 55;
  localparam int IDLE_CYCLES_DEF = 2 * FRAME_CLKS;

  typedef logic [SAMPLE_W:1]      sample_t;
  typedef logic [UART_DATA_W-1:0] data_t;

  function automatic data_t frame_data(input sample_t s);
    return s[DATA_MSB:DATA_LSB];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head output that holds its last value when empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1,
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             do_push_s, do_pop_s;
  logic [AW-1:0]    rd_next_s;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop_s  = pop & ~empty;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign do_push_s = push & (~full | do_pop_s);
  assign rd_next_s = rd_ptr_q[AW-1:0] + AW'(1);

  // Next pointers, occupancy and head byte.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + LW'(do_push_s) - LW'(do_pop_s);
    dout_d   = dout_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (level_q == LW'(1)) begin
        if (do_push_s) begin
          dout_d = din;
        end else begin
          dout_d = dout_q;
        end
      end else begin
        dout_d = mem_q[rd_next_s];
      end
    end else if (empty && do_push_s) begin
      dout_d = din;
    end else begin
      dout_d = dout_q;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dout_q   <= dout_d;
    end
  end

  assign dout  = dout_q;
  assign level = level_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive sequencer: captures each new frame on the rising edge of OK into a FIFO and
// reports overrun, occupancy, accepted-frame count and line-idle status.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int IDLE_CYCLES = IDLE_CYCLES_DEF,
  parameter int CNT_W       = 16,
  localparam int LW = $clog2(DEPTH) + 1,
  localparam int IW = $clog2(IDLE_CYCLES + 1)
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   OK,
  input  logic [SAMPLE_W:1]      SAMPLE,
  output logic [UART_DATA_W-1:0] DATA,
  output logic                   VALID,
  input  logic                   READY,
  output logic [LW-1:0]          LEVEL,
  output logic                   OVERRUN,
  input  logic                   CLR_OVR,
  output logic                   LINE_IDLE,
  output logic [CNT_W-1:0]       FRAME_CNT
);

  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);

  logic             ok_d_q, ok_d_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
  logic             line_idle_q, line_idle_d;

  logic             rise_s, pop_s, push_s, drop_s;
  logic             full_s, empty_s;
  logic             frame_unused_s;

  // Start, parity and stop bits are checked by the receiver itself.
  assign frame_unused_s = ^{SAMPLE[START_BIT], SAMPLE[PAR_BIT], SAMPLE[STOP_BIT]};

  assign rise_s = OK & ~ok_d_q;
  assign pop_s  = READY & ~empty_s;
  assign push_s = rise_s & (~full_s | pop_s);
  assign drop_s = rise_s & full_s & ~pop_s;

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (rise_s),
    .pop   (READY),
    .din   (frame_data(SAMPLE)),
    .dout  (DATA),
    .level (LEVEL),
    .full  (full_s),
    .empty (empty_s)
  );

  // Edge history, overrun flag, frame counter and idle timer.
  always_comb begin
    ok_d_d      = OK;
    overrun_d   = overrun_q;
    frame_cnt_d = frame_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    if (push_s) begin
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
    if (drop_s) begin
      overrun_d = 1'b1;
    end else if (CLR_OVR) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
    if (rise_s) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q < IDLE_MAX) begin
      idle_cnt_d = idle_cnt_q + IW'(1);
    end else begin
      idle_cnt_d = idle_cnt_q;
    end
    line_idle_d = (idle_cnt_d == IDLE_MAX);
  end

  // ok_d resets high so an OK already asserted at reset release is not taken as a new frame.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ok_d_q      <= 1'b1;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
      idle_cnt_q  <= '0;
      line_idle_q <= 1'b0;
    end else begin
      ok_d_q      <= ok_d_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      line_idle_q <= line_idle_d;
    end
  end

  assign VALID     = ~empty_s;
  assign OVERRUN   = overrun_q;
  assign LINE_IDLE = line_idle_q;
  assign FRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: a queue-based reference model predicts bytes and status,
// a monitor pops expected bytes whenever the consumer handshake completes.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;
  localparam int IDLE  = 110;
  localparam int CNT_W = 16;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        OK;
  logic [11:1] SAMPLE;
  logic [7:0]  DATA;
  logic        VALID;
  logic        READY;
  logic [3:0]  LEVEL;
  logic        OVERRUN;
  logic        CLR_OVR;
  logic        LINE_IDLE;
  logic [15:0] FRAME_CNT;

  int checks   = 0;
  int failures = 0;

  byte unsigned exp_q[$];
  int           m_level;
  int           m_cnt;
  int           m_since;
  bit           m_ovr;
  bit           m_okd;
  logic         m_rise, m_pop, m_acc;
  logic [7:0]   last_pop;
  int           pops = 0;

  always #5 CLK = ~CLK;

  uart_rx_ctrl #(.DEPTH(DEPTH), .IDLE_CYCLES(IDLE), .CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .OK        (OK),
    .SAMPLE    (SAMPLE),
    .DATA      (DATA),
    .VALID     (VALID),
    .READY     (READY),
    .LEVEL     (LEVEL),
    .OVERRUN   (OVERRUN),
    .CLR_OVR   (CLR_OVR),
    .LINE_IDLE (LINE_IDLE),
    .FRAME_CNT (FRAME_CNT)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a low-to-high step of OK; bytes queue up to DEPTH, extra ones drop.
  assign m_rise = OK & ~m_okd;
  assign m_pop  = (m_level != 0) & READY;
  assign m_acc  = m_rise & ((m_level < DEPTH) | m_pop);

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_okd   <= 1'b1;
      m_level <= 0;
      m_cnt   <= 0;
      m_ovr   <= 1'b0;
      m_since <= 0;
      exp_q.delete();
    end else begin
      m_okd   <= OK;
      m_level <= m_level + int'(m_acc) - int'(m_pop);
      if (m_acc) begin
        exp_q.push_back(SAMPLE[9:2]);
        m_cnt <= (m_cnt + 1) % (1 << CNT_W);
      end
      if (m_rise && !m_acc) m_ovr <= 1'b1;
      else if (CLR_OVR) m_ovr <= 1'b0;
      m_since <= m_rise ? 0 : ((m_since < 100000) ? m_since + 1 : m_since);
    end
  end

  // Monitor: each completed handshake must deliver the oldest outstanding byte.
  always @(posedge CLK) begin
    if (RST_N && VALID && READY) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected actual=%0h expected=none at %0t", DATA, $time);
      end else begin
        chk("pop_data", DATA, exp_q.pop_front());
      end
      last_pop = DATA;
      pops++;
    end
  end

  // Status comparison every cycle away from the active edge.
  always @(negedge CLK) begin
    if (RST_N) begin
      chk("level", LEVEL, m_level);
      chk("valid", VALID, m_level != 0);
      chk("overrun", OVERRUN, m_ovr);
      chk("frame_cnt", FRAME_CNT, m_cnt[15:0]);
      chk("line_idle", LINE_IDLE, m_since >= IDLE);
      if (m_level != 0) chk("head", DATA, exp_q[0]);
    end
  end

  task automatic send_frame(input logic [7:0] b);
    @(negedge CLK);
    OK     = 1'b0;
    SAMPLE = {1'b1, 1'($urandom_range(0, 1)), b, 1'b0};
    @(negedge CLK);
    OK = 1'b1;
  endtask

  int pops0;

  initial begin
    RST_N   = 1'b0;
    OK      = 1'b1;
    READY   = 1'b0;
    CLR_OVR = 1'b0;
    SAMPLE  = {2'b11, 8'hA5, 1'b0};
    repeat (3) @(negedge CLK);
    chk("rst_data", DATA, 32'h0);
    chk("rst_valid", VALID, 32'h0);
    chk("rst_idle", LINE_IDLE, 32'h0);
    RST_N = 1'b1;
    repeat (20) @(negedge CLK);
    chk("stale_valid", VALID, 32'h0);
    chk("stale_cnt", FRAME_CNT, 32'h0);

    // Three frames, then drain in order.
    send_frame(8'h55);
    send_frame(8'h0F);
    send_frame(8'hF0);
    @(negedge CLK);
    chk("three_level", LEVEL, 32'd3);
    chk("three_head", DATA, 32'h55);
    pops0 = pops;
    READY = 1'b1;
    repeat (4) @(negedge CLK);
    chk("three_pops", pops - pops0, 32'd3);
    chk("three_last", last_pop, 32'hF0);
    chk("three_empty", VALID, 32'h0);
    READY = 1'b0;

    // Fill to DEPTH and drop a ninth frame.
    for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i));
    send_frame(8'hEE);
    @(negedge CLK);
    chk("full_level", LEVEL, 32'd8);
    chk("full_ovr", OVERRUN, 32'd1);
    chk("full_cnt", FRAME_CNT, 32'd11);
    CLR_OVR = 1'b1;
    @(negedge CLK);
    CLR_OVR = 1'b0;
    chk("clr_ovr", OVERRUN, 32'd0);

    // Push and pop together on a full FIFO.
    OK     = 1'b0;
    SAMPLE = {2'b11, 8'h3C, 1'b0};
    @(negedge CLK);
    OK    = 1'b1;
    READY = 1'b1;
    @(negedge CLK);
    READY = 1'b0;
    chk("swap_level", LEVEL, 32'd8);
    chk("swap_ovr", OVERRUN, 32'd0);
    chk("swap_cnt", FRAME_CNT, 32'd12);
    READY = 1'b1;
    repeat (10) @(negedge CLK);
    chk("swap_last", last_pop, 32'h3C);
    chk("swap_empty", VALID, 32'h0);

    // Idle timing around a single frame.
    send_frame(8'h11);
    repeat (IDLE) @(negedge CLK);
    chk("idle_before", LINE_IDLE, 32'd0);
    @(negedge CLK);
    chk("idle_at", LINE_IDLE, 32'd1);
    send_frame(8'h22);
    @(negedge CLK);
    chk("idle_drop", LINE_IDLE, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      if ($urandom_range(0, 2) == 0) OK = ~OK;
      SAMPLE  = 11'($urandom);
      READY   = ($urandom_range(0, 2) == 0);
      CLR_OVR = ($urandom_range(0, 15) == 0);
    end

    // Drain, refill to five, then reset mid-operation.
    @(negedge CLK);
    OK      = 1'b0;
    READY   = 1'b1;
    CLR_OVR = 1'b1;
    @(negedge CLK);
    CLR_OVR = 1'b0;
    repeat (12) @(negedge CLK);
    READY = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(8'($urandom));
    @(negedge CLK);
    chk("pre_rst_level", LEVEL, 32'd5);
    #2 RST_N = 1'b0;
    #1;
    chk("async_valid", VALID, 32'h0);
    chk("async_level", LEVEL, 32'h0);
    chk("async_cnt", FRAME_CNT, 32'h0);
    @(negedge CLK);
    OK = 1'b0;
    @(negedge CLK);
    OK = 1'b1;
    SAMPLE = {2'b11, 8'h99, 1'b0};
    @(negedge CLK);
    RST_N = 1'b1;
    READY = 1'b1;
    repeat (5) @(negedge CLK);
    pops0 = pops;
    send_frame(8'h81);
    repeat (5) @(negedge CLK);
    chk("post_rst_pops", pops - pops0, 32'd1);
    chk("post_rst_byte", last_pop, 32'h81);
    chk("post_rst_cnt", FRAME_CNT, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
